// File: rtl/iomem_paket.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_paket
//  Description : Shared types and constants for the iomem responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package iomem_paket;

    // Responder state encoding
    typedef logic [1:0] durum_t;
    localparam durum_t BOS   = 2'd0;   // idle, waiting for valid
    localparam durum_t BEKLE = 2'd1;   // counting down the wait cycles
    localparam durum_t YANIT = 2'd2;   // one-cycle ready pulse

    // Read data returned for an out-of-window access
    localparam logic [31:0] HATA_VERISI = 32'hDEAD_BEEF;

    // Request as latched from the initiator in BOS
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } iomem_istek_t;

endpackage : iomem_paket
`default_nettype wire

// File: rtl/bayt_yazilabilir_bellek.sv
`default_nettype none
// ============================================================================
//  Module      : bayt_yazilabilir_bellek
//  Description : Single-port word RAM with per-byte write enables and a
//                registered read port. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module bayt_yazilabilir_bellek #(
    parameter int BELLEK_DERINLIK = 1024,
    parameter int AW              = $clog2(BELLEK_DERINLIK)
) (
    input  logic          clk_i,
    input  logic          yaz_i,
    input  logic [3:0]    bayt_en_i,
    input  logic [AW-1:0] adr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [BELLEK_DERINLIK];
    logic [31:0] rdata_q;

    // Byte-masked write and registered read of the addressed word
    always_ff @(posedge clk_i) begin
        if (yaz_i) begin
            for (int b = 0; b < 4; b++) begin
                if (bayt_en_i[b]) begin
                    mem[adr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        rdata_q <= mem[adr_i];
    end

    assign rdata_o = rdata_q;

endmodule : bayt_yazilabilir_bellek
`default_nettype wire

// File: rtl/iomem_yanitlayici.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_yanitlayici
//  Description : iomem valid/ready responder backed by a byte-writable RAM,
//                with programmable response latency, address-window decode
//                and out-of-window error flagging.
//  Revision    : 1.0 - initial release
// ============================================================================
module iomem_yanitlayici
    import iomem_paket::*;
#(
    parameter int          BELLEK_DERINLIK = 1024,
    parameter int          GECIKME         = 2,
    parameter logic [31:0] TABAN_ADRES     = 32'h4000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        iomem_valid_i,
    output logic        iomem_ready_o,
    input  logic [3:0]  iomem_wstrb_i,
    input  logic [31:0] iomem_addr_i,
    input  logic [31:0] iomem_wdata_i,
    output logic [31:0] iomem_rdata_o,
    output logic        hata_o,
    output logic        mesgul_o
);

    localparam int          AW        = $clog2(BELLEK_DERINLIK);
    localparam logic [32:0] PENCERE   = 33'(BELLEK_DERINLIK) * 33'd4;
    localparam logic [3:0]  GECIKME_C = 4'(GECIKME);

    durum_t       durum_q, durum_d;
    logic [3:0]   sayac_q, sayac_d;
    iomem_istek_t istek_q, istek_d;
    logic         ready_q, ready_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         hata_q,  hata_d;

    logic [31:0]   w_ofs;
    logic          w_pencerede;
    logic          w_yaz;
    logic [AW-1:0] w_ram_adr;
    logic [31:0]   w_ram_veri;

    // Window decode on the latched address; underflow lands far outside
    assign w_ofs       = istek_q.addr - TABAN_ADRES;
    assign w_pencerede = ({1'b0, w_ofs} < PENCERE);

    // In BOS the RAM already looks up the incoming address so that read data
    // is ready by the end of the first BEKLE cycle even with zero extra wait.
    // The base is aligned to the window size, so the raw address bits equal
    // the offset bits for any in-window address.
    assign w_ram_adr = (durum_q == BOS) ? iomem_addr_i[AW+1:2] : w_ofs[AW+1:2];

    assign w_yaz = (durum_q == BEKLE) && iomem_valid_i && (sayac_q == 4'd0)
                   && w_pencerede && (istek_q.wstrb != 4'b0000);

    bayt_yazilabilir_bellek #(
        .BELLEK_DERINLIK (BELLEK_DERINLIK),
        .AW              (AW)
    ) u_bellek (
        .clk_i     (clk_i),
        .yaz_i     (w_yaz),
        .bayt_en_i (istek_q.wstrb),
        .adr_i     (w_ram_adr),
        .wdata_i   (istek_q.wdata),
        .rdata_o   (w_ram_veri)
    );

    // Next-state, counter and registered-output logic of the responder
    always_comb begin
        durum_d = durum_q;
        sayac_d = sayac_q;
        istek_d = istek_q;
        ready_d = 1'b0;
        rdata_d = 32'd0;
        hata_d  = 1'b0;
        case (durum_q)
            BOS: begin
                if (iomem_valid_i) begin
                    istek_d = '{addr: iomem_addr_i, wstrb: iomem_wstrb_i,
                                wdata: iomem_wdata_i};
                    sayac_d = GECIKME_C;
                    durum_d = BEKLE;
                end
            end
            BEKLE: begin
                if (!iomem_valid_i) begin
                    // Initiator withdrew the request: abandon without access
                    sayac_d = 4'd0;
                    durum_d = BOS;
                end else if (sayac_q == 4'd0) begin
                    durum_d = YANIT;
                    ready_d = 1'b1;
                    if (!w_pencerede) begin
                        rdata_d = HATA_VERISI;
                        hata_d  = 1'b1;
                    end else if (istek_q.wstrb == 4'b0000) begin
                        rdata_d = w_ram_veri;
                    end
                end else begin
                    sayac_d = sayac_q - 4'd1;
                end
            end
            YANIT: begin
                durum_d = BOS;
            end
            default: begin
                durum_d = BOS;
                sayac_d = 4'd0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q <= BOS;
            sayac_q <= 4'd0;
            istek_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            hata_q  <= 1'b0;
        end else begin
            durum_q <= durum_d;
            sayac_q <= sayac_d;
            istek_q <= istek_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            hata_q  <= hata_d;
        end
    end

    assign iomem_ready_o = ready_q;
    assign iomem_rdata_o = rdata_q;
    assign hata_o        = hata_q;
    assign mesgul_o      = (durum_q != BOS);

endmodule : iomem_yanitlayici
`default_nettype wire

// File: tb/tb_iomem_yanitlayici.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iomem_yanitlayici
//  Description : Self-checking bench for iomem_yanitlayici; one instance with
//                two wait cycles and one with none, both compared against a
//                word-array memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_yanitlayici;

    localparam logic [31:0] TABAN = 32'h4000_0000;
    localparam logic [31:0] HATA  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid [2];
    logic [3:0]  wstrb [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic [31:0] rdata [2];
    logic        hata  [2];
    logic        mesgul[2];

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [2][1024];
    bit          bilinen [2][1024];

    always #5 clk = ~clk;

    iomem_yanitlayici #(.BELLEK_DERINLIK(1024), .GECIKME(2), .TABAN_ADRES(TABAN)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .iomem_valid_i(valid[0]), .iomem_ready_o(ready[0]),
        .iomem_wstrb_i(wstrb[0]), .iomem_addr_i(addr[0]), .iomem_wdata_i(wdata[0]),
        .iomem_rdata_o(rdata[0]), .hata_o(hata[0]), .mesgul_o(mesgul[0]));

    iomem_yanitlayici #(.BELLEK_DERINLIK(1024), .GECIKME(0), .TABAN_ADRES(TABAN)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .iomem_valid_i(valid[1]), .iomem_ready_o(ready[1]),
        .iomem_wstrb_i(wstrb[1]), .iomem_addr_i(addr[1]), .iomem_wdata_i(wdata[1]),
        .iomem_rdata_o(rdata[1]), .hata_o(hata[1]), .mesgul_o(mesgul[1]));

    task automatic kontrol(input string tag, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        checks++;
        if (gozlenen !== beklenen) begin
            errors++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, gozlenen, beklenen, $time);
        end
    endtask

    // Reference behaviour: apply the access to the word array and return
    // what the responder should present in its ready cycle.
    task automatic model(input int k, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] er,
                         output logic eh, output bit bilinir);
        logic [31:0] off;
        int          idx;
        off = a - TABAN;
        er = 32'd0; eh = 1'b0; bilinir = 1'b1;
        if (off < 32'd4096) begin
            idx = int'(off >> 2);
            if (s != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[k][idx][8*b +: 8] = d[8*b +: 8];
                if (s == 4'hF) bilinen[k][idx] = 1'b1;
            end else begin
                er = ref_mem[k][idx];
                bilinir = bilinen[k][idx];
            end
        end else begin
            er = HATA;
            eh = 1'b1;
        end
    endtask

    // One complete transaction with latency, data, flag and return-to-zero checks
    task automatic islem(input int k, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] er;
        logic        eh;
        bit          bilinir;
        bit          bulundu;
        int          n;
        model(k, a, s, d, er, eh, bilinir);
        @(negedge clk);
        valid[k] = 1'b1; addr[k] = a; wstrb[k] = s; wdata[k] = d;
        bulundu = 1'b0; n = 0;
        while (!bulundu && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) kontrol("mesgul_aktif", 32'(mesgul[k]), 32'd1);
            if (ready[k]) bulundu = 1'b1;
        end
        kontrol("gecikme", 32'(n), (k == 0) ? 32'd4 : 32'd2);
        if (bulundu) begin
            if (bilinir) kontrol("rdata", rdata[k], er);
            kontrol("hata", 32'(hata[k]), 32'(eh));
        end
        valid[k] = 1'b0;
        @(posedge clk); #1;
        kontrol("ready_tek_darbe", 32'(ready[k]), 32'd0);
        kontrol("rdata_sifir", rdata[k], 32'd0);
        kontrol("hata_sifir", 32'(hata[k]), 32'd0);
        kontrol("mesgul_bos", 32'(mesgul[k]), 32'd0);
    endtask

    function automatic logic [31:0] rastgele_adr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7)       return TABAN + (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
        else if (r == 7) return TABAN + 32'd4096 + (32'($urandom_range(0, 255)) << 2);
        else if (r == 8) return TABAN - (32'($urandom_range(1, 64)) << 2);
        else             return TABAN + 32'd4092;
    endfunction

    initial begin
        logic [31:0] er;
        logic        eh;
        bit          bilinir;
        bit          goruldu;
        int          n;
        for (int k = 0; k < 2; k++) begin
            valid[k] = 1'b0; wstrb[k] = 4'h0; addr[k] = 32'd0; wdata[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            kontrol("reset_ready", 32'(ready[k]), 32'd0);
            kontrol("reset_rdata", rdata[k], 32'd0);
            kontrol("reset_hata", 32'(hata[k]), 32'd0);
            kontrol("reset_mesgul", 32'(mesgul[k]), 32'd0);
        end
        @(negedge clk); rst = 1'b1;

        // Full write then read back, wait-2 instance
        islem(0, 32'h4000_0010, 4'hF, 32'hA5A5_1234);
        islem(0, 32'h4000_0010, 4'h0, 32'd0);

        // Populate the region the random phase uses
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++)
                if (!(k == 0 && i == 4)) islem(k, TABAN + 32'(i * 4), 4'hF, $urandom);
            islem(k, TABAN + 32'd4092, 4'hF, $urandom);
        end

        // Byte strobes
        islem(0, 32'h4000_0020, 4'hF, 32'h1122_3344);
        islem(0, 32'h4000_0020, 4'b0101, 32'hAABB_CCDD);
        islem(0, 32'h4000_0020, 4'h0, 32'd0);
        kontrol("strobe_model", ref_mem[0][8], 32'h11BB_33DD);

        // Out of window reads and writes
        islem(0, 32'h4000_1000, 4'h0, 32'd0);
        islem(0, 32'h3FFF_FFFC, 4'h0, 32'd0);
        islem(0, 32'h4000_1000, 4'hF, 32'h0BAD_0BAD);
        islem(0, 32'h3FFF_FFFC, 4'hF, 32'h0BAD_0BAD);
        islem(0, 32'h4000_0000, 4'h0, 32'd0);
        islem(0, 32'h4000_0FFC, 4'h0, 32'd0);

        // Zero-wait instance: valid held across eight reads
        @(negedge clk);
        valid[1] = 1'b1; wstrb[1] = 4'h0; addr[1] = TABAN;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                kontrol("ardisik_ready", 32'(ready[1]), 32'd0);
            end
            model(1, TABAN + 32'(i * 4), 4'h0, 32'd0, er, eh, bilinir);
            n = 0; goruldu = 1'b0;
            while (!goruldu && n < 20) begin
                @(posedge clk); #1;
                n++;
                if (ready[1]) goruldu = 1'b1;
            end
            kontrol("ardisik_gecikme", 32'(n), 32'd2);
            kontrol("ardisik_rdata", rdata[1], er);
            if (i < 7) addr[1] = TABAN + 32'((i + 1) * 4);
            else valid[1] = 1'b0;
        end
        @(posedge clk); #1;
        kontrol("ardisik_son_ready", 32'(ready[1]), 32'd0);

        // Abort: valid withdrawn in the first wait cycle of a write
        islem(0, 32'h4000_0004, 4'hF, 32'h0102_0304);
        @(negedge clk);
        valid[0] = 1'b1; addr[0] = 32'h4000_0004; wstrb[0] = 4'hF; wdata[0] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        kontrol("iptal_mesgul_aktif", 32'(mesgul[0]), 32'd1);
        @(negedge clk); valid[0] = 1'b0;
        goruldu = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready[0]) goruldu = 1'b1;
        end
        kontrol("iptal_ready", 32'(goruldu), 32'd0);
        kontrol("iptal_mesgul", 32'(mesgul[0]), 32'd0);
        islem(0, 32'h4000_0004, 4'h0, 32'd0);

        // Asynchronous reset in the middle of a wait
        @(negedge clk);
        valid[0] = 1'b1; addr[0] = 32'h4000_0010; wstrb[0] = 4'h0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        kontrol("async_mesgul", 32'(mesgul[0]), 32'd0);
        kontrol("async_ready", 32'(ready[0]), 32'd0);
        kontrol("async_rdata", rdata[0], 32'd0);
        valid[0] = 1'b0;
        #2 rst = 1'b1;
        islem(0, 32'h4000_0010, 4'h0, 32'd0);

        // Randomized traffic on both instances
        for (int i = 0; i < 80; i++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            islem(i % 2, rastgele_adr(), s, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_iomem_yanitlayici
`default_nettype wire

// File: doc/iomem_yanitlayici.md
Name: iomem_yanitlayici

Overview:
- Responder (slave) end of the iomem valid/ready bus that the processor top drives as initiator.
- Word-addressed, byte-writable on-chip RAM model with programmable response latency, address-window decode and error flagging.
- Serves as a standalone iomem target for SoC integration and as the memory model behind the processor in simulation.

Parameters:
- BELLEK_DERINLIK, 1024, number of 32-bit words (power of 2, at least 2).
- GECIKME, 2, extra wait cycles before ready (0..15).
- TABAN_ADRES, 32'h4000_0000, byte base address of the window (aligned to BELLEK_DERINLIK*4).

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- iomem_valid_i  input  1  initiator request.
- iomem_ready_o  output  1  one-cycle completion pulse.
- iomem_wstrb_i  input  4  byte enables; 4'b0000 means read.
- iomem_addr_i  input  32  byte address; bits [1:0] ignored.
- iomem_wdata_i  input  32  write data.
- iomem_rdata_o  output  32  read data, valid only while ready is high.
- hata_o  output  1  out-of-window pulse, coincident with ready.
- mesgul_o  output  1  high while a transaction is in progress (state is not BOS).

Behaviour:
- Reset: while rst_i is low, state=BOS, iomem_ready_o=0, iomem_rdata_o=0, hata_o=0, mesgul_o=0, counter=0.
  - Asserting reset mid-transaction aborts it. No write occurs.
  - RAM contents are not reset.
- States: BOS, BEKLE, YANIT.
- BOS:
  - If iomem_valid_i=1, latch addr, wstrb, wdata, load counter with GECIKME, and go to BEKLE.
  - Otherwise stay in BOS.
- BEKLE:
  - If counter=0, perform the access and go to YANIT. Otherwise decrement the counter.
  - If iomem_valid_i drops (protocol violation), go to BOS with no access and no ready.
- YANIT:
  - iomem_ready_o=1 for exactly this cycle. Next state is BOS unconditionally.
- Latency: if valid first goes high in cycle c, ready is high in cycle c+GECIKME+2. The next transaction can begin sampling in cycle c+GECIKME+3. There is no back-to-back overlap.
- Decode:
  - off = latched_addr - TABAN_ADRES (32-bit unsigned).
  - In window when off < BELLEK_DERINLIK*4.
  - Index = off[log2(DERINLIK)+1:2].
- Access on the BEKLE to YANIT edge:
  - Write (wstrb != 0, in window): update only the bytes with wstrb[i]=1. iomem_rdata_o is 0.
  - Read (in window): iomem_rdata_o is a registered copy of mem[index].
  - Out of window: no write. iomem_rdata_o=32'hDEAD_BEEF. hata_o=1 in the YANIT cycle.
- Outputs are registered. iomem_rdata_o and hata_o return to 0 on the cycle after YANIT.
- The initiator holds addr, wstrb and wdata stable while valid is high. The block uses only the values latched in BOS.
- Address wrap: subtraction that underflows yields a large off value, which is treated as out of window (e.g. addr 32'h3FFF_FFFC).

Decomposition:
- Shared package iomem_paket:
  - state enum (BOS, BEKLE, YANIT)
  - HATA_VERISI = 32'hDEAD_BEEF
  - iomem request struct (addr, wstrb, wdata)
- Sub-module bayt_yazilabilir_bellek: synchronous single-port RAM with 4-bit byte-enable write and registered read, BELLEK_DERINLIK words.
- The FSM, counter and decode stay in iomem_yanitlayici.

Test Plan:
- Reset release, GECIKME=2: write 32'hA5A5_1234 to 32'h4000_0010 with wstrb=4'hF, valid rising in cycle 5 -> ready only in cycle 9, hata_o=0. A read of the same address returns 32'hA5A5_1234.
- Byte strobes: preload 32'h1122_3344 at 32'h4000_0020, write wdata=32'hAABB_CCDD with wstrb=4'b0101 -> read back 32'h11BB_33DD.
- Out of window: read 32'h4000_1000 and 32'h3FFF_FFFC (DERINLIK=1024) -> ready with rdata=32'hDEAD_BEEF and hata_o=1. Writes to those addresses leave all RAM contents unchanged.
- GECIKME=0: 8 consecutive reads with valid held and addresses incremented after each ready -> each ready arrives 2 cycles after its valid; ready is never high on two consecutive cycles.
- Abort: valid dropped in the first BEKLE cycle of a write to 32'h4000_0004 -> no ready pulse, and the word at 32'h4000_0004 is unchanged.
- Async reset: rst_i low for half a cycle during BEKLE -> outputs 0 immediately. After release, a fresh read completes normally.
